// File: rtl/bsg_fsb_router.sv
// Front-side-bus ring router: one inbound and one outbound 1-entry register,
// destination delivery to local nodes, command decoding and round-robin egress.
module bsg_fsb_router #(
  parameter int unsigned         width_p                = 80,
  parameter int unsigned         nodes_p                = 4,
  parameter int unsigned         id_width_p             = 4,
  parameter logic [nodes_p-1:0]  enabled_at_start_vec_p = '0,
  parameter int unsigned         reset_cycles_p         = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       loopback_i,
  input  logic                       asm_v_i,
  input  logic [width_p-1:0]         asm_data_i,
  output logic                       asm_yumi_o,
  output logic                       asm_v_o,
  output logic [width_p-1:0]         asm_data_o,
  input  logic                       asm_ready_i,
  output logic [nodes_p-1:0]         node_v_o,
  output logic [width_p-1:0]         node_data_o,
  input  logic [nodes_p-1:0]         node_ready_i,
  input  logic [nodes_p-1:0]         node_v_i,
  input  logic [nodes_p*width_p-1:0] node_data_i,
  output logic [nodes_p-1:0]         node_yumi_o,
  output logic [nodes_p-1:0]         node_en_r_o,
  output logic [nodes_p-1:0]         node_reset_r_o,
  output logic [15:0]                drop_count_r_o
);

  localparam int unsigned ptr_w = (nodes_p > 1) ? $clog2(nodes_p) : 1;
  localparam int unsigned cnt_w = $clog2(reset_cycles_p + 1);

  logic                  in_v_r;
  logic [width_p-1:0]    in_data_r;
  logic                  out_v_r;
  logic [width_p-1:0]    out_data_r;
  logic [ptr_w-1:0]      rr_ptr_r;
  logic [cnt_w-1:0]      rst_cnt_r;

  logic [id_width_p-1:0] dest;
  logic [id_width_p-1:0] tgt;
  logic [1:0]            op;
  logic                  is_cmd;
  logic [nodes_p-1:0]    dest_oh;
  logic [nodes_p-1:0]    tgt_oh;

  logic                  out_load;
  logic                  in_drain;
  logic                  lb_xfer;
  logic                  drop;
  logic                  cmd_exec;

  logic [nodes_p-1:0]    req;
  logic [nodes_p-1:0]    gnt_oh;
  logic                  gnt_found;
  logic                  gnt_v;
  logic [ptr_w-1:0]      gnt_next_ptr;
  logic [width_p-1:0]    gnt_data;

  assign dest   = in_data_r[width_p-1 -: id_width_p];
  assign tgt    = in_data_r[2 +: id_width_p];
  assign op     = in_data_r[1:0];
  assign is_cmd = &dest;

  // One-hot decodes; out-of-range ids decode to zero and so act on no node.
  always_comb begin
    dest_oh = '0;
    tgt_oh  = '0;
    for (int k = 0; k < int'(nodes_p); k++) begin
      dest_oh[k] = (int'(dest) == k);
      tgt_oh[k]  = (int'(tgt) == k);
    end
  end

  assign out_load = ~out_v_r | asm_ready_i;

  // Inbound entry disposition: command, loopback, delivery or drop.
  always_comb begin
    in_drain = 1'b0;
    lb_xfer  = 1'b0;
    drop     = 1'b0;
    cmd_exec = 1'b0;
    node_v_o = '0;
    if (in_v_r) begin
      if (is_cmd) begin
        if (!(op == 2'd2 && rst_cnt_r != '0)) begin
          cmd_exec = 1'b1;
          in_drain = 1'b1;
        end
      end else if (loopback_i) begin
        lb_xfer  = out_load;
        in_drain = out_load;
      end else if (|(dest_oh & node_en_r_o)) begin
        node_v_o = dest_oh;
        in_drain = |(dest_oh & node_ready_i);
      end else begin
        drop     = 1'b1;
        in_drain = 1'b1;
      end
    end
  end

  assign asm_yumi_o  = reset_n_i & asm_v_i & (~in_v_r | in_drain);
  assign node_data_o = in_data_r;

  // Round-robin search starting at rr_ptr_r.
  assign req = node_v_i & node_en_r_o;
  always_comb begin
    int idx;
    idx          = 0;
    gnt_oh       = '0;
    gnt_found    = 1'b0;
    gnt_next_ptr = rr_ptr_r;
    for (int i = 0; i < int'(nodes_p); i++) begin
      idx = int'(rr_ptr_r) + i;
      if (idx >= int'(nodes_p)) idx = idx - int'(nodes_p);
      for (int k = 0; k < int'(nodes_p); k++) begin
        if (!gnt_found && req[k] && idx == k) begin
          gnt_oh[k]    = 1'b1;
          gnt_found    = 1'b1;
          gnt_next_ptr = (k == int'(nodes_p) - 1) ? '0 : ptr_w'(k + 1);
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < int'(nodes_p); k++) begin
      if (gnt_oh[k]) gnt_data = node_data_i[k*width_p +: width_p];
    end
  end

  assign gnt_v       = out_load & ~lb_xfer & gnt_found;
  assign node_yumi_o = (reset_n_i & gnt_v) ? gnt_oh : '0;
  assign asm_v_o     = out_v_r;
  assign asm_data_o  = out_data_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      in_v_r    <= 1'b0;
      in_data_r <= '0;
    end else if (asm_yumi_o) begin
      in_v_r    <= 1'b1;
      in_data_r <= asm_data_i;
    end else if (in_drain) begin
      in_v_r    <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      out_v_r    <= 1'b0;
      out_data_r <= '0;
      rr_ptr_r   <= '0;
    end else begin
      if (out_load) begin
        out_v_r <= lb_xfer | gnt_v;
        if (lb_xfer)    out_data_r <= in_data_r;
        else if (gnt_v) out_data_r <= gnt_data;
      end
      if (gnt_v) rr_ptr_r <= gnt_next_ptr;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      node_en_r_o    <= enabled_at_start_vec_p;
      drop_count_r_o <= '0;
    end else begin
      if (cmd_exec && op == 2'd0) node_en_r_o <= node_en_r_o | tgt_oh;
      if (cmd_exec && op == 2'd1) node_en_r_o <= node_en_r_o & ~tgt_oh;
      if (cmd_exec && op == 2'd3)
        drop_count_r_o <= '0;
      else if (drop && drop_count_r_o != 16'hFFFF)
        drop_count_r_o <= drop_count_r_o + 16'd1;
    end
  end

  // Shared pulse counter: reset-release window and op-2 node pulses.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      node_reset_r_o <= '1;
      rst_cnt_r      <= cnt_w'(reset_cycles_p);
    end else if (cmd_exec && op == 2'd2 && |tgt_oh) begin
      node_reset_r_o <= tgt_oh;
      rst_cnt_r      <= cnt_w'(reset_cycles_p);
    end else if (rst_cnt_r != '0) begin
      rst_cnt_r <= rst_cnt_r - cnt_w'(1);
      if (rst_cnt_r == cnt_w'(1)) node_reset_r_o <= '0;
    end
  end

endmodule

// File: tb/tb_bsg_fsb_router.sv
// Directed bench for bsg_fsb_router: vector table for delivery/drop/commands,
// hand sequences for reset pulses, round-robin, loopback and mid-transfer reset.
module tb_bsg_fsb_router;

  localparam int unsigned W = 80;
  localparam int unsigned N = 4;

  logic           clk_i = 1'b0;
  logic           reset_n_i;
  logic           loopback_i;
  logic           asm_v_i;
  logic [W-1:0]   asm_data_i;
  logic           asm_yumi_o;
  logic           asm_v_o;
  logic [W-1:0]   asm_data_o;
  logic           asm_ready_i;
  logic [N-1:0]   node_v_o;
  logic [W-1:0]   node_data_o;
  logic [N-1:0]   node_ready_i;
  logic [N-1:0]   node_v_i;
  logic [N*W-1:0] node_data_i;
  logic [N-1:0]   node_yumi_o;
  logic [N-1:0]   node_en_r_o;
  logic [N-1:0]   node_reset_r_o;
  logic [15:0]    drop_count_r_o;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [W-1:0] pkt;
    logic [N-1:0] exp_nv;
    logic [15:0]  exp_drop;
    logic [N-1:0] exp_en;
  } vec_t;

  bsg_fsb_router #(
    .width_p(W), .nodes_p(N), .id_width_p(4),
    .enabled_at_start_vec_p(4'b0000), .reset_cycles_p(16)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .loopback_i(loopback_i),
    .asm_v_i(asm_v_i), .asm_data_i(asm_data_i), .asm_yumi_o(asm_yumi_o),
    .asm_v_o(asm_v_o), .asm_data_o(asm_data_o), .asm_ready_i(asm_ready_i),
    .node_v_o(node_v_o), .node_data_o(node_data_o), .node_ready_i(node_ready_i),
    .node_v_i(node_v_i), .node_data_i(node_data_i), .node_yumi_o(node_yumi_o),
    .node_en_r_o(node_en_r_o), .node_reset_r_o(node_reset_r_o),
    .drop_count_r_o(drop_count_r_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [W-1:0] mk_data(input logic [3:0] d, input logic [75:0] p);
    return {d, p};
  endfunction

  function automatic logic [W-1:0] mk_cmd(input logic [1:0] op, input logic [3:0] n);
    return {4'hF, 70'h0, n, op};
  endfunction

  function automatic logic [W-1:0] nd(input int k);
    return {4'hA, 72'hCAFE_0000, 4'(k)};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  // Present one packet, wait (bounded) for consumption; returns at the negedge
  // of the cycle in which the packet sits in the inbound entry.
  task automatic send(input logic [W-1:0] pkt);
    logic ok;
    ok = 1'b0;
    @(posedge clk_i); #1;
    asm_v_i    = 1'b1;
    asm_data_i = pkt;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk_i);
      if (asm_yumi_o) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk_i); #1;
    end
    chk("yumi_wait", 128'(ok), 128'(1'b1));
    @(posedge clk_i); #1;
    asm_v_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic send_en(input logic [W-1:0] pkt, input logic [N-1:0] exp_en);
    send(pkt);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("cmd_en", 128'(node_en_r_o), 128'(exp_en));
  endtask

  initial begin
    vec_t         vecs [12];
    logic [W-1:0] seen [4];
    logic [W-1:0] lb_pkt [3];
    logic [N-1:0] exp4;
    int got, hi0, hi1, first0, last1;

    vecs[0]  = '{mk_cmd(2'd0, 4'd2),          4'b0000, 16'd0, 4'b0100};
    vecs[1]  = '{mk_data(4'd2, 76'h1234_5678), 4'b0100, 16'd0, 4'b0100};
    vecs[2]  = '{mk_data(4'd3, 76'hBEEF),      4'b0000, 16'd1, 4'b0100};
    vecs[3]  = '{mk_data(4'd9, 76'hF00D),      4'b0000, 16'd2, 4'b0100};
    vecs[4]  = '{mk_data(4'd4, 76'h0042),      4'b0000, 16'd3, 4'b0100};
    vecs[5]  = '{mk_cmd(2'd3, 4'd0),           4'b0000, 16'd0, 4'b0100};
    vecs[6]  = '{mk_cmd(2'd0, 4'd9),           4'b0000, 16'd0, 4'b0100};
    vecs[7]  = '{mk_cmd(2'd1, 4'd2),           4'b0000, 16'd0, 4'b0000};
    vecs[8]  = '{mk_data(4'd2, 76'h7777),      4'b0000, 16'd1, 4'b0000};
    vecs[9]  = '{mk_cmd(2'd0, 4'd0),           4'b0000, 16'd1, 4'b0001};
    vecs[10] = '{mk_data(4'd0, 76'hABCDE),     4'b0001, 16'd1, 4'b0001};
    vecs[11] = '{mk_cmd(2'd3, 4'd0),           4'b0000, 16'd0, 4'b0001};

    for (int k = 0; k < int'(N); k++) node_data_i[k*W +: W] = nd(k);
    reset_n_i    = 1'b0;
    loopback_i   = 1'b0;
    asm_v_i      = 1'b0;
    asm_data_i   = '0;
    asm_ready_i  = 1'b1;
    node_ready_i = '1;
    node_v_i     = '0;

    // Reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_asm_v",   128'(asm_v_o),        128'(1'b0));
    chk("rst_node_v",  128'(node_v_o),       128'(4'b0000));
    chk("rst_en",      128'(node_en_r_o),    128'(4'b0000));
    chk("rst_drop",    128'(drop_count_r_o), 128'(16'd0));
    chk("rst_nreset",  128'(node_reset_r_o), 128'(4'b1111));
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;

    // Table: delivery, drops, enable/disable commands, counter clear
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].pkt);
      chk("vec_node_v", 128'(node_v_o), 128'(vecs[i].exp_nv));
      if (vecs[i].exp_nv != '0) chk("vec_node_data", 128'(node_data_o), 128'(vecs[i].pkt));
      @(posedge clk_i); #1;
      @(negedge clk_i);
      chk("vec_drop", 128'(drop_count_r_o), 128'(vecs[i].exp_drop));
      chk("vec_en",   128'(node_en_r_o),    128'(vecs[i].exp_en));
    end

    // Commands: enable 1, pulse node 1, then back-to-back pulse on node 0 stalls
    send_en(mk_cmd(2'd0, 4'd1), 4'b0011);
    @(posedge clk_i); #1;
    asm_v_i    = 1'b1;
    asm_data_i = mk_cmd(2'd2, 4'd1);
    @(negedge clk_i);
    chk("pulse1_yumi", 128'(asm_yumi_o), 128'(1'b1));
    @(posedge clk_i); #1;
    asm_data_i = mk_cmd(2'd2, 4'd0);
    @(negedge clk_i);
    chk("pulse0_yumi", 128'(asm_yumi_o), 128'(1'b1));
    @(posedge clk_i); #1;
    asm_v_i = 1'b0;
    hi0 = 0; hi1 = 0; first0 = -1; last1 = -1;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk_i);
      if (node_reset_r_o[1]) begin hi1++; last1 = i; end
      if (node_reset_r_o[0]) begin hi0++; if (first0 < 0) first0 = i; end
    end
    chk("pulse1_len",   128'(hi1),    128'(16));
    chk("pulse1_end",   128'(last1),  128'(15));
    chk("pulse0_start", 128'(first0), 128'(17));
    chk("pulse0_len",   128'(hi0),    128'(16));

    // Round-robin: enable all, grants 0,1,2,3,0, then backpressure
    send_en(mk_cmd(2'd0, 4'd2), 4'b0111);
    send_en(mk_cmd(2'd0, 4'd3), 4'b1111);
    @(posedge clk_i); #1;
    asm_ready_i = 1'b1;
    node_v_i    = '1;
    for (int g = 0; g < 5; g++) begin
      @(negedge clk_i);
      exp4 = 4'(1 << (g % 4));
      chk("rr_yumi", 128'(node_yumi_o), 128'(exp4));
      if (g > 0) chk("rr_data", 128'(asm_data_o), 128'(nd((g - 1) % 4)));
      @(posedge clk_i); #1;
    end
    asm_ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      chk("bp_yumi", 128'(node_yumi_o), 128'(4'b0000));
      chk("bp_hold", 128'(asm_data_o),  128'(nd(0)));
      @(posedge clk_i); #1;
    end
    node_v_i    = '0;
    asm_ready_i = 1'b1;

    // Loopback: three inbound packets egress in order ahead of node grants
    @(posedge clk_i); #1;
    loopback_i = 1'b1;
    lb_pkt[0] = mk_data(4'd1, 76'h111);
    lb_pkt[1] = mk_data(4'd2, 76'h222);
    lb_pkt[2] = mk_data(4'd0, 76'h333);
    got = 0;
    for (int c = 0; c < 12; c++) begin
      if (c < 3) begin asm_v_i = 1'b1; asm_data_i = lb_pkt[c]; end
      else asm_v_i = 1'b0;
      if (c == 1) node_v_i = '1;
      @(negedge clk_i);
      if (c < 3) chk("lb_yumi", 128'(asm_yumi_o), 128'(1'b1));
      if (c < 4) chk("lb_no_grant", 128'(node_yumi_o), 128'(4'b0000));
      if (asm_v_o && got < 4) begin seen[got] = asm_data_o; got++; end
      @(posedge clk_i); #1;
    end
    chk("lb_count", 128'(got), 128'(4));
    for (int i = 0; i < 3; i++) chk("lb_order", 128'(seen[i]), 128'(lb_pkt[i]));
    chk("lb_then_node", 128'(seen[3]), 128'(nd(1)));
    loopback_i = 1'b0;
    node_v_i   = '0;
    repeat (2) @(posedge clk_i);
    #1;

    // Mid-transfer reset with both registers occupied
    asm_ready_i  = 1'b0;
    node_ready_i = '0;
    node_v_i     = 4'b0001;
    asm_v_i      = 1'b1;
    asm_data_i   = mk_data(4'd2, 76'h999);
    repeat (2) @(posedge clk_i);
    #1;
    @(negedge clk_i);
    chk("full_out",  128'(asm_v_o),  128'(1'b1));
    chk("full_in",   128'(node_v_o), 128'(4'b0100));
    @(posedge clk_i); #1;
    reset_n_i = 1'b0;
    #1;
    chk("mrst_asm_v",  128'(asm_v_o),        128'(1'b0));
    chk("mrst_yumi",   128'(asm_yumi_o),     128'(1'b0));
    chk("mrst_node_v", 128'(node_v_o),       128'(4'b0000));
    chk("mrst_nyumi",  128'(node_yumi_o),    128'(4'b0000));
    chk("mrst_en",     128'(node_en_r_o),    128'(4'b0000));
    chk("mrst_nreset", 128'(node_reset_r_o), 128'(4'b1111));
    asm_v_i      = 1'b0;
    node_v_i     = '0;
    node_ready_i = '1;
    asm_ready_i  = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    hi0 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (node_reset_r_o == 4'b1111) hi0++;
      if (i == 0) begin
        chk("post_asm_v",  128'(asm_v_o),  128'(1'b0));
        chk("post_node_v", 128'(node_v_o), 128'(4'b0000));
      end
    end
    chk("post_rst_len",   128'(hi0),            128'(16));
    chk("post_rst_clear", 128'(node_reset_r_o), 128'(4'b0000));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bsg_fsb_router.md
BSG_FSB_ROUTER -- requirements
Module: bsg_fsb_router

Interface
REQ-001 The router SHALL have these parameters:
- width_p, default 80: ring packet width in bits.
- nodes_p, default 4: number of attached nodes, 1..15.
- id_width_p, default 4: width of the destination field; 2^id_width_p-1 SHALL exceed nodes_p-1.
- enabled_at_start_vec_p, default 0: node_en_r_o value after reset.
- reset_cycles_p, default 16: node reset pulse length in cycles, at least 2.

REQ-002 The router SHALL have these ports (name, direction, width, meaning):
- clk_i, in, 1: sole clock.
- reset_n_i, in, 1: asynchronous, active-low reset.
- loopback_i, in, 1: return inbound packets to asm out.
- asm_v_i, in, 1: inbound packet valid from the comm link.
- asm_data_i, in, width_p: inbound packet.
- asm_yumi_o, out, 1: inbound packet consumed.
- asm_v_o, out, 1: outbound packet valid.
- asm_data_o, out, width_p: outbound packet.
- asm_ready_i, in, 1: comm link accepts outbound packet.
- node_v_o, out, nodes_p: per-node delivery valid.
- node_data_o, out, width_p: shared delivery bus.
- node_ready_i, in, nodes_p: node accepts delivery.
- node_v_i, in, nodes_p: node has an outbound packet.
- node_data_i, in, nodes_p*width_p: node packets; node k occupies slice k.
- node_yumi_o, out, nodes_p: node packet consumed.
- node_en_r_o, out, nodes_p: registered node enables.
- node_reset_r_o, out, nodes_p: registered node resets.
- drop_count_r_o, out, 16: count of dropped packets.

Function
REQ-003 The destination field SHALL be dest = data[width_p-1 -: id_width_p]; dest equal to all-ones SHALL mark a command packet.

REQ-004 The inbound path SHALL use a 1-entry register (in_v_r, in_data_r).
- asm_yumi_o = asm_v_i & (~in_v_r | in_drain), where in_drain means the entry leaves this cycle.
- Packets SHALL reach the node side 1 cycle after asm_yumi_o.

REQ-005 A non-command entry with dest<nodes_p, node_en_r_o[dest]=1 and loopback_i=0 SHALL drive node_v_o[dest]=1 and node_data_o=in_data_r. It SHALL drain on node_ready_i[dest]=1. All other node_v_o bits SHALL be 0.

REQ-006 A non-command entry with dest>=nodes_p, or with its destination node disabled, SHALL drain in 1 cycle and increment drop_count_r_o. The counter SHALL saturate at 16'hFFFF.

REQ-007 A command entry SHALL decode op = data[1:0] and target n = data[2+:id_width_p]. It SHALL execute and drain in 1 cycle:
- op 0: set node_en_r_o[n].
- op 1: clear node_en_r_o[n].
- op 2: start a reset pulse on node n.
- op 3: clear drop_count_r_o.
- op 0-2 with n>=nodes_p: no effect; the command is still drained and not counted as a drop.

REQ-008 The reset pulse SHALL use one shared down-counter.
- node_reset_r_o[n] SHALL be 1 for exactly reset_cycles_p cycles, beginning the cycle after the command drains.
- An op-2 command arriving while the counter is non-zero SHALL stall in the entry until the counter reaches 0.
- Enable and data paths SHALL be unaffected by the pulse.

REQ-009 With loopback_i=1, a non-command entry SHALL bypass the nodes and be moved into the outbound register. Loopback SHALL have priority over node grants. loopback_i SHALL be sampled only when a packet is at the head of the inbound entry.

REQ-010 The outbound path SHALL use a 1-entry register (out_v_r, out_data_r).
- asm_v_o=out_v_r and asm_data_o=out_data_r.
- The register SHALL load when empty or when asm_ready_i & out_v_r.

REQ-011 Outbound arbitration SHALL be round-robin among node_v_i & node_en_r_o.
- At most one node_yumi_o bit SHALL be 1 per cycle, and only when the register loads and no loopback transfer occurs.
- The pointer SHALL advance to the node after the winner.
- After reset, node 0 SHALL have the highest priority.

REQ-012 A node disabled in cycle t SHALL NOT be granted from cycle t+1.

REQ-013 With the outbound register full and asm_ready_i=0, no node_yumi_o SHALL assert and a loopback entry SHALL stall.

Reset
REQ-014 While reset_n_i=0, the following SHALL hold:
- in_v_r=0, out_v_r=0, asm_yumi_o=0, node_v_o=0, node_yumi_o=0.
- node_en_r_o=enabled_at_start_vec_p, drop_count_r_o=0, arbiter pointer=0.
- node_reset_r_o all ones.

REQ-015 After reset_n_i rises, node_reset_r_o SHALL stay all ones for reset_cycles_p cycles, then clear. An op-2 command received in this window SHALL stall.

REQ-016 Assertion of reset_n_i mid-transfer SHALL discard all buffered packets without handshake.

Verification
REQ-017 The bench SHALL cover:
- Delivery: nodes_p=4, node 2 enabled, packet with dest=2 -> node_v_o=4'b0100 one cycle after asm_yumi_o, data intact.
- Drop: dest=3 with node 3 disabled, then dest=9 -> both consumed, drop_count_r_o=2, node_v_o stays 0.
- Commands: op0 n=1, then op2 n=1, then op2 n=0 immediately -> node_en_r_o[1]=1; node_reset_r_o[1] high exactly 16 cycles; second command stalls, then pulses node 0.
- Round-robin: all nodes valid and enabled, asm_ready_i=1 -> grants 0,1,2,3,0; with asm_ready_i=0 for 5 cycles, no yumi.
- Loopback: loopback_i=1, nodes 0-3 valid, 3 inbound packets -> 3 inbound packets appear on asm_data_o in order before any node grant.
- Reset: reset_n_i low with both registers full -> outputs per REQ-014 immediately; node_reset_r_o clears 16 cycles after release.
